// File: rtl/eth_idma_meta_splitter.sv
// Burst splitter for the Ethernet iDMA meta channel: turns one 1D transfer into
// AXI4 bursts (page and max-length split) or AXI-Stream segments (max-length split).
module eth_idma_meta_splitter #(
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned TFLenWidth = 32,
    parameter int unsigned IdWidth    = 5,
    parameter int unsigned MaxBeats   = 256,
    parameter int unsigned PageSize   = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [AddrWidth-1:0]  req_addr_i,
    input  logic [TFLenWidth-1:0] req_len_i,
    input  logic                  req_proto_i,
    input  logic [IdWidth-1:0]    req_id_i,
    output logic                  meta_valid_o,
    input  logic                  meta_ready_i,
    output logic [AddrWidth-1:0]  meta_addr_o,
    output logic [7:0]            meta_len_o,
    output logic [TFLenWidth-1:0] meta_bytes_o,
    output logic                  meta_proto_o,
    output logic [IdWidth-1:0]    meta_id_o,
    output logic                  meta_first_o,
    output logic                  meta_last_o,
    output logic                  done_o,
    output logic                  busy_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffWidth  = $clog2(StrbWidth);
    localparam int unsigned W         = TFLenWidth + 1;

    localparam logic [W-1:0] MAX_BYTES = W'(MaxBeats * StrbWidth);
    localparam logic [W-1:0] PAGE_BYTES = W'(PageSize);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SPLIT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]            state_r;
    logic [AddrWidth-1:0]  addr_r;
    logic [TFLenWidth-1:0] remaining_r;
    logic                  proto_r;
    logic [IdWidth-1:0]    id_r;
    logic                  first_r;

    logic [W-1:0]          off_s;
    logic [W-1:0]          max_rem_s;
    logic [W-1:0]          page_rem_s;
    logic [W-1:0]          rem_s;
    logic [W-1:0]          bytes_s;
    logic [7:0]            len_s;
    logic                  last_s;
    logic                  in_split_s;

    function automatic logic [W-1:0] min_w(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a < b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    // Burst size decode from the current address and remaining byte count
    always_comb begin
        off_s      = W'(addr_r & AddrWidth'(StrbWidth - 1));
        max_rem_s  = MAX_BYTES - off_s;
        page_rem_s = PAGE_BYTES - W'(addr_r & AddrWidth'(PageSize - 1));
        rem_s      = W'(remaining_r);
        if (proto_r) begin
            bytes_s = min_w(rem_s, max_rem_s);
        end else begin
            bytes_s = min_w(min_w(rem_s, max_rem_s), page_rem_s);
        end
        // Beats minus one = ceil((off + bytes) / strb) - 1, with bytes >= 1 in SPLIT
        len_s      = 8'((off_s + bytes_s - W'(1)) >> OffWidth);
        last_s     = (bytes_s == rem_s);
        in_split_s = (state_r == ST_SPLIT);
    end

    // Transfer FSM and per-burst address/length bookkeeping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            remaining_r <= '0;
            proto_r     <= 1'b0;
            id_r        <= '0;
            first_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        addr_r      <= req_addr_i;
                        remaining_r <= req_len_i;
                        proto_r     <= req_proto_i;
                        id_r        <= req_id_i;
                        first_r     <= 1'b1;
                        if (req_len_i == '0) begin
                            state_r <= ST_DONE;
                        end else begin
                            state_r <= ST_SPLIT;
                        end
                    end
                end
                ST_SPLIT: begin
                    if (meta_ready_i) begin
                        addr_r      <= addr_r + AddrWidth'(bytes_s);
                        remaining_r <= remaining_r - TFLenWidth'(bytes_s);
                        first_r     <= 1'b0;
                        if (last_s) begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode; descriptor fields are forced to zero outside SPLIT
    always_comb begin
        req_ready_o  = (state_r == ST_IDLE) && !rst_i;
        meta_valid_o = in_split_s;
        done_o       = (state_r == ST_DONE);
        busy_o       = (state_r != ST_IDLE);
        if (in_split_s) begin
            meta_addr_o  = addr_r;
            meta_len_o   = len_s;
            meta_bytes_o = TFLenWidth'(bytes_s);
            meta_proto_o = proto_r;
            meta_id_o    = id_r;
            meta_first_o = first_r;
            meta_last_o  = last_s;
        end else begin
            meta_addr_o  = '0;
            meta_len_o   = 8'd0;
            meta_bytes_o = '0;
            meta_proto_o = 1'b0;
            meta_id_o    = '0;
            meta_first_o = 1'b0;
            meta_last_o  = 1'b0;
        end
    end

endmodule

// File: doc/eth_idma_meta_splitter.md
Name: eth_idma_meta_splitter

Overview:
- Parametrised burst splitter feeding the iDMA read/write meta channel of the Ethernet DMA path.
- Accepts one 1D transfer (address, byte length, protocol, id) at a time.
- Emits a stream of protocol-legal burst descriptors: AXI4 bursts, split at page boundaries and at max burst length, or AXI-Stream segments, split at max length only.
- Sits between the iDMA front-end and the AXI/AXIS legalised meta channel.

Parameters:
- AddrWidth, 64, address width.
- DataWidth, 64, bus data width; StrbWidth = DataWidth/8 bytes per beat (power of two, >=8 bits).
- TFLenWidth, 32, transfer length width in bytes.
- IdWidth, 5, transfer id width.
- MaxBeats, 256, max beats per burst/segment (power of two, 1..256).
- PageSize, 4096, AXI no-cross boundary in bytes (power of two, >= MaxBeats*StrbWidth not required).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  1  transfer request valid
- req_ready_o  out  1  transfer request ready
- req_addr_i  in  AddrWidth  start byte address
- req_len_i  in  TFLenWidth  length in bytes
- req_proto_i  in  1  0 = AXI4, 1 = AXI-Stream
- req_id_i  in  IdWidth  transfer id
- meta_valid_o  out  1  burst descriptor valid
- meta_ready_i  in  1  burst descriptor ready
- meta_addr_o  out  AddrWidth  burst start address
- meta_len_o  out  8  beats minus one (AXI len encoding)
- meta_bytes_o  out  TFLenWidth  bytes carried by this burst
- meta_proto_o  out  1  protocol of the burst
- meta_id_o  out  IdWidth  id of the owning transfer
- meta_first_o  out  1  first burst of the transfer
- meta_last_o  out  1  last burst of the transfer
- done_o  out  1  one-cycle pulse when the transfer has completed
- busy_o  out  1  splitter holds an active transfer

Behaviour:
- Clock/reset: clock clk_i; rst_i is asynchronous, active-high. While rst_i is high, every register clears immediately (FSM returns to IDLE, remaining = 0) and all outputs are 0, except req_ready_o, which is 0 during reset and 1 in IDLE afterwards. Reset mid-transfer discards the transfer; no done_o is issued.
- FSM states:
  - IDLE: req_ready_o = 1. On req_valid_i && req_ready_o, latch addr, len, proto and id.
    - len == 0: go to DONE.
    - otherwise: go to SPLIT, first_flag = 1.
  - SPLIT: meta_valid_o = 1; descriptor comes from the current registers (registered-state, combinational decode). On meta_valid_o && meta_ready_i:
    - addr += bytes; remaining -= bytes; first_flag = 0.
    - If meta_last_o, go to DONE; else stay in SPLIT. One burst per cycle with no bubble.
  - DONE: done_o = 1 for exactly one cycle, then IDLE.
- Burst size: off = addr mod StrbWidth.
  - max_rem = MaxBeats*StrbWidth - off.
  - page_rem = PageSize - (addr mod PageSize), applied for AXI only.
  - AXI: bytes = min(remaining, max_rem, page_rem).
  - AXIS: bytes = min(remaining, max_rem).
  - meta_len_o = ceil((off + bytes)/StrbWidth) - 1.
  - meta_last_o = (bytes == remaining).
  - All arithmetic is unsigned, TFLenWidth+1 bits internally. Address increments wrap modulo 2^AddrWidth with no error.
- Latency: request accepted in cycle T gives first meta_valid_o in T+1. Zero-length: done_o in T+1, no descriptor.
- Handshake: once meta_valid_o rises, all meta_* outputs stay stable until meta_ready_i. meta_valid_o never drops without a handshake, except on reset.
- Ordering: req_ready_o = 0 in SPLIT and DONE, so the next request is accepted no earlier than the cycle after done_o.
- busy_o = (state != IDLE).

Test Plan:
- AXI, addr 0x1000, len 0x100 -> one burst: addr 0x1000, len 31, bytes 256, first = last = 1; done_o the cycle after the handshake.
- AXI, addr 0x0FF0, len 0x20 -> two bursts:
  - addr 0x0FF0, bytes 16, len 1, first = 1;
  - addr 0x1000, bytes 16, len 1, last = 1.
- AXIS, same addr/len -> one burst: bytes 32, len 3, first = last = 1 (no page split).
- AXI, addr 0x0, len 0x1000 -> bursts at 0x0 and 0x800, each bytes 2048, len 255. Unaligned AXI addr 0x6, len 4 -> bytes 4, len 1.
- Backpressure: meta_ready_i = 0 for 5 cycles mid-transfer -> meta_* stable and meta_valid_o held. Zero-length request -> no meta_valid_o, done_o in T+1.
- rst_i asserted during SPLIT -> meta_valid_o and busy_o low immediately (same cycle, asynchronous). After release, req_ready_o = 1 and a new transfer splits correctly.
